adder_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit: the generalised successor to the team's single-register 8-bit sequential adder. The carry chain is split into `STAGES` equal chunks, one chunk per register stage, giving one result per clock at `STAGES` cycles of latency. Per-beat modes select add or subtract, unsigned or signed interpretation, and wrap or saturate on overflow. A valid flag travels with each beat. The block sits between operand registers and downstream datapath logic wherever a wide add must close timing.

---
 rtl/adder_pipe.sv | 183 ++++++++++++++++++
 tb/tb_adder_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with optional signed/unsigned saturation, carry chain split into STAGES chunks.
// Latency: a beat sampled at edge N is on the outputs after edge N+STAGES-1; one beat per clock.
// Backpressure: none; every beat is accepted, bubbles (in_valid=0) flow through and leave outputs held.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_mode,
  input  logic             sat,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
  end

  // Bits of carry chain handled by each stage.
  localparam int C = WIDTH / STAGES;

  // Leading stages: each adds its chunk, registers the chunk carry, carries the
  // not-yet-consumed operand bits forward and the finished low result bits along.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_pipe
    localparam int LO = k * C;
    localparam int AW = WIDTH - LO;

    logic [AW-1:0]     w_a;
    logic [AW-1:0]     w_b;
    logic              w_vld;
    logic              w_cin;
    logic              w_sub;
    logic              w_sgn;
    logic              w_sat;
    logic [C-1:0]      w_bx;
    logic [C:0]        w_sum;
    logic [LO+C-1:0]   w_res;

    logic              r_vld;
    logic              r_cy;
    logic              r_sub;
    logic              r_sgn;
    logic              r_sat;
    logic [AW-C-1:0]   r_a;
    logic [AW-C-1:0]   r_b;
    logic [LO+C-1:0]   r_lo;

    if (k == 0) begin : g_src
      // The subtract "+1" enters as the carry into the lowest chunk.
      assign w_a   = a;
      assign w_b   = b;
      assign w_vld = in_valid;
      assign w_cin = sub;
      assign w_sub = sub;
      assign w_sgn = signed_mode;
      assign w_sat = sat;
      assign w_res = w_sum[C-1:0];
    end else begin : g_src
      assign w_a   = g_pipe[k-1].r_a;
      assign w_b   = g_pipe[k-1].r_b;
      assign w_vld = g_pipe[k-1].r_vld;
      assign w_cin = g_pipe[k-1].r_cy;
      assign w_sub = g_pipe[k-1].r_sub;
      assign w_sgn = g_pipe[k-1].r_sgn;
      assign w_sat = g_pipe[k-1].r_sat;
      assign w_res = {w_sum[C-1:0], g_pipe[k-1].r_lo};
    end

    assign w_bx  = w_sub ? ~w_b[C-1:0] : w_b[C-1:0];
    assign w_sum = {1'b0, w_a[C-1:0]} + {1'b0, w_bx} + {{C{1'b0}}, w_cin};

    // Stage register: chunk carry, skewed upper operands, deskewed low result, per-beat modes.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_sub <= 1'b0;
        r_sgn <= 1'b0;
        r_sat <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_lo  <= '0;
      end else begin
        r_vld <= w_vld;
        r_cy  <= w_sum[C];
        r_sub <= w_sub;
        r_sgn <= w_sgn;
        r_sat <= w_sat;
        r_a   <= w_a[AW-1:C];
        r_b   <= w_b[AW-1:C];
        r_lo  <= w_res;
      end
    end
  end

  // Final stage: top chunk, flags and saturation.
  logic [C-1:0]     w_fa;
  logic [C-1:0]     w_fb;
  logic [C-1:0]     w_fbx;
  logic             w_fvld;
  logic             w_fcin;
  logic             w_fsub;
  logic             w_fsgn;
  logic             w_fsat;
  logic [C:0]       w_fsum;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_satv;
  logic [WIDTH-1:0] w_y;
  logic             w_cmsb;
  logic             w_ovf;

  logic             r_vld;
  logic [WIDTH-1:0] r_y;
  logic             r_cy;
  logic             r_ovf;

  if (STAGES == 1) begin : g_fsrc
    assign w_fa   = a;
    assign w_fb   = b;
    assign w_fvld = in_valid;
    assign w_fcin = sub;
    assign w_fsub = sub;
    assign w_fsgn = signed_mode;
    assign w_fsat = sat;
    assign w_raw  = w_fsum[C-1:0];
  end else begin : g_fsrc
    assign w_fa   = g_pipe[STAGES-2].r_a;
    assign w_fb   = g_pipe[STAGES-2].r_b;
    assign w_fvld = g_pipe[STAGES-2].r_vld;
    assign w_fcin = g_pipe[STAGES-2].r_cy;
    assign w_fsub = g_pipe[STAGES-2].r_sub;
    assign w_fsgn = g_pipe[STAGES-2].r_sgn;
    assign w_fsat = g_pipe[STAGES-2].r_sat;
    assign w_raw  = {w_fsum[C-1:0], g_pipe[STAGES-2].r_lo};
  end

  assign w_fbx  = w_fsub ? ~w_fb : w_fb;
  assign w_fsum = {1'b0, w_fa} + {1'b0, w_fbx} + {{C{1'b0}}, w_fcin};
  // Carry into the MSB is recovered from the MSB sum bit, so no extra adder split is needed.
  assign w_cmsb = w_fa[C-1] ^ w_fbx[C-1] ^ w_fsum[C-1];
  assign w_ovf  = w_fsgn ? (w_cmsb ^ w_fsum[C]) : (w_fsub ? ~w_fsum[C] : w_fsum[C]);
  assign w_y    = (w_fsat && w_ovf) ? w_satv : w_raw;

  // Clamp value: signed side chosen by the sign of operand A, unsigned by add/sub direction.
  always_comb begin
    w_satv = '0;
    if (w_fsgn) begin
      w_satv = w_fa[C-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else if (!w_fsub) begin
      w_satv = '1;
    end
  end

  // Output register: valid every beat, data and flags only on valid beats.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_vld <= 1'b0;
      r_y   <= '0;
      r_cy  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_vld <= w_fvld;
      if (w_fvld) begin
        r_y   <= w_y;
        r_cy  <= w_fsum[C];
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = r_vld;
  assign y         = r_y;
  assign carry     = r_cy;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: four configurations (8/1, 8/4, 8/2, 32/4) against an arithmetic model.
// Latency: model delays each beat by the configured stage count.
// Backpressure: none exercised; inputs driven on falling edges, outputs checked on falling edges.
module tb_adder_pipe;

  localparam int WD [4] = '{8, 8, 8, 32};
  localparam int SD [4] = '{1, 4, 2, 4};

  logic        clock;
  logic        resetn;
  logic        tv   [4];
  logic [31:0] ta   [4];
  logic [31:0] tbb  [4];
  logic        tsub [4];
  logic        tsgn [4];
  logic        tsat [4];

  logic        ov [4];
  logic        oc [4];
  logic        oo [4];
  logic [31:0] oy [4];
  logic [7:0]  y0, y1, y2;
  logic [31:0] y3;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  // model delay line and held expected result {carry, overflow, y}
  logic        hv [4][4];
  logic [33:0] hr [4][4];
  logic [33:0] er [4];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  adder_pipe #(.WIDTH(8), .STAGES(1)) u_w8s1 (
    .clock(clock), .resetn(resetn), .in_valid(tv[0]), .a(ta[0][7:0]), .b(tbb[0][7:0]),
    .sub(tsub[0]), .signed_mode(tsgn[0]), .sat(tsat[0]),
    .out_valid(ov[0]), .y(y0), .carry(oc[0]), .overflow(oo[0]));

  adder_pipe #(.WIDTH(8), .STAGES(4)) u_w8s4 (
    .clock(clock), .resetn(resetn), .in_valid(tv[1]), .a(ta[1][7:0]), .b(tbb[1][7:0]),
    .sub(tsub[1]), .signed_mode(tsgn[1]), .sat(tsat[1]),
    .out_valid(ov[1]), .y(y1), .carry(oc[1]), .overflow(oo[1]));

  adder_pipe #(.WIDTH(8), .STAGES(2)) u_w8s2 (
    .clock(clock), .resetn(resetn), .in_valid(tv[2]), .a(ta[2][7:0]), .b(tbb[2][7:0]),
    .sub(tsub[2]), .signed_mode(tsgn[2]), .sat(tsat[2]),
    .out_valid(ov[2]), .y(y2), .carry(oc[2]), .overflow(oo[2]));

  adder_pipe #(.WIDTH(32), .STAGES(4)) u_w32s4 (
    .clock(clock), .resetn(resetn), .in_valid(tv[3]), .a(ta[3]), .b(tbb[3]),
    .sub(tsub[3]), .signed_mode(tsgn[3]), .sat(tsat[3]),
    .out_valid(ov[3]), .y(y3), .carry(oc[3]), .overflow(oo[3]));

  assign oy[0] = {24'd0, y0};
  assign oy[1] = {24'd0, y1};
  assign oy[2] = {24'd0, y2};
  assign oy[3] = y3;

  // Exact-integer model: true sum/difference compared with the representable range.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic s, input logic g, input logic t);
    longint mask, ua, ub, sa, sb, ur, sr, smax, smin, yv;
    logic c, o;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
    sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
    ur   = s ? ua - ub : ua + ub;
    sr   = s ? sa - sb : sa + sb;
    smax = mask >> 1;
    smin = -(smax + 1);
    c    = s ? (ua >= ub) : (ur > mask);
    o    = g ? (sr > smax || sr < smin) : (ur < 0 || ur > mask);
    yv   = ur & mask;
    if (t && o) begin
      if (g) yv = (sr > smax) ? smax : (smin & mask);
      else   yv = s ? 0 : mask;
    end
    return {c, o, yv[31:0]};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int i, input logic v, input logic [31:0] yy,
                         input logic c, input logic o);
    cmp({nm, " out_valid"}, {31'd0, ov[i]}, {31'd0, v});
    cmp({nm, " y"}, oy[i], yy);
    cmp({nm, " carry"}, {31'd0, oc[i]}, {31'd0, c});
    cmp({nm, " overflow"}, {31'd0, oo[i]}, {31'd0, o});
  endtask

  task automatic drv(input int i, input logic v, input logic [31:0] av, input logic [31:0] bv,
                     input logic s, input logic g, input logic t);
    tv[i] = v; ta[i] = av; tbb[i] = bv; tsub[i] = s; tsgn[i] = g; tsat[i] = t;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Model: each beat emerges STAGES edges after sampling; result held across bubbles.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        er[i] <= '0;
        for (int k = 0; k < 4; k++) begin
          hv[i][k] <= 1'b0;
          hr[i][k] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 1; k < 4; k++) begin
          hv[i][k] <= hv[i][k-1];
          hr[i][k] <= hr[i][k-1];
        end
        hv[i][0] <= tv[i];
        hr[i][0] <= model(WD[i], ta[i], tbb[i], tsub[i], tsgn[i], tsat[i]);
        if (SD[i] == 1) begin
          if (tv[i]) er[i] <= model(WD[i], ta[i], tbb[i], tsub[i], tsgn[i], tsat[i]);
        end else if (hv[i][SD[i]-2]) begin
          er[i] <= hr[i][SD[i]-2];
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        cmp($sformatf("model i%0d out_valid", i), {31'd0, ov[i]}, {31'd0, hv[i][SD[i]-1]});
        cmp($sformatf("model i%0d y", i), oy[i], er[i][31:0]);
        cmp($sformatf("model i%0d carry", i), {31'd0, oc[i]}, {31'd0, er[i][33]});
        cmp($sformatf("model i%0d overflow", i), {31'd0, oo[i]}, {31'd0, er[i][32]});
      end
    end
  end

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) drv(i, 0, 0, 0, 0, 0, 0);

    // pin the model against hand-computed values
    cmp("pin ff+1", {30'd0, model(8, 32'hFF, 32'h1, 0, 0, 0)}, {30'd0, 1'b1, 1'b1, 32'h00});
    cmp("pin ff+1 sat", {30'd0, model(8, 32'hFF, 32'h1, 0, 0, 1)}, {30'd0, 1'b1, 1'b1, 32'hFF});
    cmp("pin 3-5", {30'd0, model(8, 32'h3, 32'h5, 1, 0, 0)}, {30'd0, 1'b0, 1'b1, 32'hFE});
    cmp("pin 80-1 sgn sat", {30'd0, model(8, 32'h80, 32'h1, 1, 1, 1)}, {30'd0, 1'b1, 1'b1, 32'h80});
    cmp("pin 7f+1 sgn sat", {30'd0, model(8, 32'h7F, 32'h1, 0, 1, 1)}, {30'd0, 1'b0, 1'b1, 32'h7F});
    cmp("pin w32", {30'd0, model(32, 32'hFFFF, 32'h1, 0, 0, 0)}, {30'd0, 1'b0, 1'b0, 32'h10000});

    step(); step();
    for (int i = 0; i < 4; i++) chk_out($sformatf("reset i%0d", i), i, 0, 0, 0, 0);
    resetn = 1'b1;
    chk_on = 1'b1;

    // W8 S1 unsigned add stream
    step(); drv(0, 1, 2, 3, 0, 0, 0);
    step(); chk_out("s1 2+3", 0, 1, 5, 0, 0);   drv(0, 1, 4, 5, 0, 0, 0);
    step(); chk_out("s1 4+5", 0, 1, 9, 0, 0);   drv(0, 1, 10, 30, 0, 0, 0);
    step(); chk_out("s1 10+30", 0, 1, 40, 0, 0); drv(0, 0, 0, 0, 0, 0, 0);
    step(); chk_out("s1 bubble", 0, 0, 40, 0, 0);

    // W8 S1 unsigned sub 3-5
    drv(0, 1, 3, 5, 1, 0, 0);
    step(); chk_out("s1 3-5", 0, 1, 32'hFE, 0, 1); drv(0, 1, 3, 5, 1, 0, 1);
    step(); chk_out("s1 3-5 sat", 0, 1, 32'h00, 0, 1); drv(0, 0, 0, 0, 0, 0, 0);

    // W8 S4 0xFF+1 without and with saturation
    drv(1, 1, 32'hFF, 1, 0, 0, 0);
    step(); drv(1, 1, 32'hFF, 1, 0, 0, 1);
    step(); drv(1, 0, 0, 0, 0, 0, 0);
    step(); chk_out("s4 early", 1, 0, 0, 0, 0);
    step(); chk_out("s4 ff+1", 1, 1, 32'h00, 1, 1);
    step(); chk_out("s4 ff+1 sat", 1, 1, 32'hFF, 1, 1);
    step(); chk_out("s4 drain", 1, 0, 32'hFF, 1, 1);

    // W8 S2 signed saturation, differing modes back to back
    drv(2, 1, 32'h7F, 1, 0, 1, 1);
    step(); drv(2, 1, 32'h80, 1, 1, 1, 1);
    step(); chk_out("s2 7f+1", 2, 1, 32'h7F, 0, 1); drv(2, 0, 0, 0, 0, 0, 0);
    step(); chk_out("s2 80-1", 2, 1, 32'h80, 1, 1);

    // W32 S4 carry across chunk boundaries with a bubble
    drv(3, 1, 32'h0000FFFF, 1, 0, 0, 0);
    step(); drv(3, 0, 0, 0, 0, 0, 0);
    step(); drv(3, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
    step(); drv(3, 0, 0, 0, 0, 0, 0);
    step(); chk_out("w32 ffff+1", 3, 1, 32'h00010000, 0, 0);
    step(); chk_out("w32 bubble", 3, 0, 32'h00010000, 0, 0);
    step(); chk_out("w32 wrap", 3, 1, 32'h0, 1, 1);
    step(); chk_out("w32 drain", 3, 0, 32'h0, 1, 1);

    // Reset with three beats in flight on W8 S4
    drv(1, 1, 10, 1, 0, 0, 0);
    step(); drv(1, 1, 20, 1, 0, 0, 0);
    step(); drv(1, 1, 30, 1, 0, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    #1 chk_out("rst async s4", 1, 0, 0, 0, 0);
    chk_out("rst async w32", 3, 0, 0, 0, 0);
    #1 resetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step(); chk_out($sformatf("rst drop %0d", n), 1, 0, 0, 0, 0);
    end
    drv(1, 1, 1, 1, 0, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk_out("rst pre 1+1", 1, 0, 0, 0, 0);
    step(); chk_out("rst 1+1", 1, 1, 2, 0, 0);
    step(); chk_out("rst after", 1, 0, 2, 0, 0);

    step(); step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
